// File: rtl/knn_classifier.sv
// k-nearest-neighbour classifier: streams labelled training points against a query,
// keeps a stable sorted list of the K nearest, and runs a sequential majority vote.
module knn_classifier #(
  parameter int unsigned COORD_W = 16,
  parameter int unsigned DIMS    = 2,
  parameter int unsigned K       = 10,
  parameter int unsigned LABEL_W = 3,
  localparam int unsigned DIST_W = 2*COORD_W + $clog2(DIMS),
  localparam int unsigned CNT_W  = $clog2(K+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      test_load,
  input  logic [DIMS*COORD_W-1:0]   test_point,
  input  logic                      train_valid,
  output logic                      train_ready,
  input  logic [DIMS*COORD_W-1:0]   train_point,
  input  logic [LABEL_W-1:0]        train_label,
  input  logic                      classify,
  output logic                      busy,
  output logic                      done,
  output logic [LABEL_W-1:0]        result_label,
  output logic [CNT_W-1:0]          result_votes,
  output logic [CNT_W-1:0]          nb_count,
  output logic [K*DIST_W-1:0]       nb_dist,
  output logic [K*LABEL_W-1:0]      nb_label
);

  localparam int unsigned NLAB   = 2**LABEL_W;
  localparam int unsigned PT_W   = DIMS*COORD_W;
  localparam int unsigned SLOT_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_VOTE, S_ARGMAX, S_DONE} state_t;

  state_t state, next_state;
  logic   load_c, start_c, accept_c;

  logic [PT_W-1:0]    query;
  logic               s1_valid;
  logic [DIST_W-1:0]  s1_dist;
  logic [LABEL_W-1:0] s1_label;

  logic [DIST_W-1:0]  slot_dist  [K];
  logic [LABEL_W-1:0] slot_label [K];
  logic [K-1:0]       occ;

  logic [CNT_W-1:0]   cnt [NLAB];
  logic [SLOT_W-1:0]  vote_slot;
  logic [LABEL_W-1:0] arg_lab;
  logic [LABEL_W-1:0] best_label;
  logic [CNT_W-1:0]   best_cnt;

  logic [COORD_W-1:0] coord_a, coord_b, diff;
  logic [DIST_W-1:0]  dist_c;

  logic [K-1:0]       gt;
  logic [K:0]         gtx;
  logic [DIST_W-1:0]  ext_dist  [K];
  logic [LABEL_W-1:0] ext_label [K];
  logic [K-1:0]       ext_occ;
  logic [DIST_W-1:0]  ins_dist  [K];
  logic [LABEL_W-1:0] ins_label [K];
  logic [K-1:0]       ins_occ;

  assign train_ready = (state == S_IDLE) && !test_load && !classify;
  assign accept_c    = train_valid && train_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // FSM next state and control strobes
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    start_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (test_load) begin
          load_c = 1'b1;
        end else if (classify) begin
          start_c    = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN:  next_state = S_VOTE;
      S_VOTE:   if (vote_slot == SLOT_W'(K-1)) next_state = S_ARGMAX;
      S_ARGMAX: if (arg_lab == {LABEL_W{1'b1}}) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Exact squared Euclidean distance of the incoming beat to the query
  always_comb begin
    dist_c  = '0;
    coord_a = '0;
    coord_b = '0;
    diff    = '0;
    for (int d = 0; d < int'(DIMS); d++) begin
      coord_a = train_point[d*COORD_W +: COORD_W];
      coord_b = query[d*COORD_W +: COORD_W];
      diff    = (coord_a >= coord_b) ? (coord_a - coord_b) : (coord_b - coord_a);
      dist_c  = dist_c + DIST_W'(diff) * DIST_W'(diff);
    end
  end

  // Insertion: gt[] is a monotone mask; its first set bit is the insert position
  always_comb begin
    for (int i = 0; i < int'(K); i++) begin
      gt[i] = !occ[i] || (slot_dist[i] > s1_dist);
    end
    gtx = {gt, 1'b0};
    ext_dist[0]  = s1_dist;
    ext_label[0] = s1_label;
    ext_occ      = '0;
    ext_occ[0]   = 1'b1;
    for (int i = 1; i < int'(K); i++) begin
      ext_dist[i]  = slot_dist[i-1];
      ext_label[i] = slot_label[i-1];
      ext_occ[i]   = occ[i-1];
    end
    ins_occ = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (!gt[i]) begin
        ins_dist[i]  = slot_dist[i];
        ins_label[i] = slot_label[i];
        ins_occ[i]   = occ[i];
      end else if (!gtx[i]) begin
        ins_dist[i]  = ext_dist[0];
        ins_label[i] = ext_label[0];
        ins_occ[i]   = 1'b1;
      end else begin
        ins_dist[i]  = ext_dist[i];
        ins_label[i] = ext_label[i];
        ins_occ[i]   = ext_occ[i];
      end
    end
  end

  // Datapath: stage-1 register, neighbour list, vote and argmax, results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      query        <= '0;
      s1_valid     <= 1'b0;
      s1_dist      <= '0;
      s1_label     <= '0;
      occ          <= '0;
      nb_count     <= '0;
      result_label <= '0;
      result_votes <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      vote_slot    <= '0;
      arg_lab      <= '0;
      best_label   <= '0;
      best_cnt     <= '0;
      for (int i = 0; i < int'(K); i++) begin
        slot_dist[i]  <= '0;
        slot_label[i] <= '0;
      end
      for (int l = 0; l < int'(NLAB); l++) cnt[l] <= '0;
    end else begin
      done <= (state == S_DONE);
      busy <= (state != S_IDLE);
      if (load_c) begin
        query        <= test_point;
        s1_valid     <= 1'b0;
        occ          <= '0;
        nb_count     <= '0;
        result_label <= '0;
        result_votes <= '0;
      end else begin
        s1_valid <= accept_c;
        if (accept_c) begin
          s1_dist  <= dist_c;
          s1_label <= train_label;
        end
        if (s1_valid) begin
          for (int i = 0; i < int'(K); i++) begin
            slot_dist[i]  <= ins_dist[i];
            slot_label[i] <= ins_label[i];
          end
          occ <= ins_occ;
          if (nb_count != CNT_W'(K)) nb_count <= nb_count + CNT_W'(1);
        end
        if (state == S_DONE) begin
          result_label <= best_label;
          result_votes <= best_cnt;
        end
      end
      case (state)
        S_DRAIN: begin
          for (int l = 0; l < int'(NLAB); l++) cnt[l] <= '0;
          vote_slot  <= '0;
          arg_lab    <= '0;
          best_label <= '0;
          best_cnt   <= '0;
        end
        S_VOTE: begin
          if (occ[vote_slot]) begin
            cnt[slot_label[vote_slot]] <= cnt[slot_label[vote_slot]] + CNT_W'(1);
          end
          vote_slot <= vote_slot + SLOT_W'(1);
        end
        S_ARGMAX: begin
          // strictly greater keeps the lowest label on ties
          if (cnt[arg_lab] > best_cnt) begin
            best_cnt   <= cnt[arg_lab];
            best_label <= arg_lab;
          end
          arg_lab <= arg_lab + LABEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nb_dist  = '0;
    nb_label = '0;
    for (int i = 0; i < int'(K); i++) begin
      nb_dist[i*DIST_W +: DIST_W]    = slot_dist[i];
      nb_label[i*LABEL_W +: LABEL_W] = slot_label[i];
    end
  end

endmodule

// File: tb/tb_knn_classifier.sv
// Directed bench for knn_classifier (K=3, LABEL_W=2, DIMS=2, COORD_W=16).
module tb_knn_classifier;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned DIMS    = 2;
  localparam int unsigned K       = 3;
  localparam int unsigned LABEL_W = 2;
  localparam int unsigned DIST_W  = 33;
  localparam int unsigned CNT_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    test_load;
  logic [DIMS*COORD_W-1:0] test_point;
  logic                    train_valid;
  logic                    train_ready;
  logic [DIMS*COORD_W-1:0] train_point;
  logic [LABEL_W-1:0]      train_label;
  logic                    classify;
  logic                    busy;
  logic                    done;
  logic [LABEL_W-1:0]      result_label;
  logic [CNT_W-1:0]        result_votes;
  logic [CNT_W-1:0]        nb_count;
  logic [K*DIST_W-1:0]     nb_dist;
  logic [K*LABEL_W-1:0]    nb_label;

  int checks   = 0;
  int failures = 0;
  logic saw_done;

  knn_classifier #(.COORD_W(COORD_W), .DIMS(DIMS), .K(K), .LABEL_W(LABEL_W)) dut (
    .clk(clk), .rst(rst), .test_load(test_load), .test_point(test_point),
    .train_valid(train_valid), .train_ready(train_ready), .train_point(train_point),
    .train_label(train_label), .classify(classify), .busy(busy), .done(done),
    .result_label(result_label), .result_votes(result_votes), .nb_count(nb_count),
    .nb_dist(nb_dist), .nb_label(nb_label)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pt(input int unsigned x, input int unsigned y);
    return {y[15:0], x[15:0]};
  endfunction

  task automatic load(input int unsigned x, input int unsigned y);
    test_load  = 1'b1;
    test_point = pt(x, y);
    step();
    test_load  = 1'b0;
  endtask

  task automatic train(input int unsigned x, input int unsigned y, input int unsigned l);
    train_valid = 1'b1;
    train_point = pt(x, y);
    train_label = LABEL_W'(l);
    step();
    train_valid = 1'b0;
  endtask

  task automatic run_classify(input string tag, input int unsigned lab, input int unsigned votes);
    classify = 1'b1;
    step();
    classify = 1'b0;
    for (int i = 0; i < 30 && !done; i++) step();
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_label"}, 128'(result_label), 128'(lab));
    chk({tag, "_votes"}, 128'(result_votes), 128'(votes));
  endtask

  initial begin
    rst = 1'b1; test_load = 1'b0; test_point = '0; train_valid = 1'b0;
    train_point = '0; train_label = '0; classify = 1'b0;
    step(); step();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_count", 128'(nb_count), 128'(0));
    chk("rst_dist", 128'(nb_dist), 128'(0));
    chk("rst_result", 128'({result_label, result_votes}), 128'(0));
    rst = 1'b0;
    step();
    chk("idle_ready", 128'(train_ready), 128'(1));

    // single point: list updates on the second edge after the beat is presented
    load(0, 0);
    train(3, 4, 1);
    chk("pipe_lat", 128'(nb_count), 128'(0));
    step();
    chk("single_count", 128'(nb_count), 128'(1));
    chk("single_dist", 128'(nb_dist[32:0]), 128'(25));
    chk("single_label", 128'(nb_label[1:0]), 128'(1));

    // back-to-back insertion with stable ties and drop of the farthest
    load(0, 0);
    train(3, 4, 1); train(0, 3, 2); train(4, 3, 3); train(1, 0, 0);
    step(); step();
    chk("sort_count", 128'(nb_count), 128'(3));
    chk("sort_dist", 128'(nb_dist), 128'({33'd25, 33'd9, 33'd1}));
    chk("sort_label", 128'(nb_label), 128'({2'd1, 2'd2, 2'd0}));

    // nonzero query, |a-b| in both directions
    load(10, 20);
    train(7, 24, 2);
    step();
    chk("absdiff_dist", 128'(nb_dist[32:0]), 128'(25));

    // majority vote with exact timing; beats offered while busy must be refused
    load(0, 0);
    train(1, 0, 0); train(2, 0, 2); train(3, 0, 2);
    step(); step();
    classify = 1'b1;
    step();
    classify = 1'b0;
    chk("cls_e0_busy", 128'(busy), 128'(0));
    chk("cls_e0_ready", 128'(train_ready), 128'(0));
    train_valid = 1'b1; train_point = pt(0, 0); train_label = 2'd3;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 8) train_valid = 1'b0;
      chk($sformatf("cls_e%0d_busy", e), 128'(busy), 128'(e <= 9));
      chk($sformatf("cls_e%0d_done", e), 128'(done), 128'(e == 9));
      if (e <= 9) chk($sformatf("cls_e%0d_ready", e), 128'(train_ready), 128'(e == 9));
    end
    chk("cls_label", 128'(result_label), 128'(2));
    chk("cls_votes", 128'(result_votes), 128'(2));
    chk("cls_no_accept", 128'(nb_count), 128'(3));
    chk("cls_nearest", 128'(nb_dist[32:0]), 128'(1));

    // three-way tie resolves to the lowest label
    load(0, 0);
    train(1, 0, 3); train(2, 0, 1); train(3, 0, 2);
    step(); step();
    run_classify("tie", 1, 1);

    // empty list after reload
    load(0, 0);
    chk("reload_result", 128'({result_label, result_votes}), 128'(0));
    chk("reload_count", 128'(nb_count), 128'(0));
    run_classify("empty", 0, 0);

    // widest distance fits DIST_W exactly
    load(0, 0);
    train(65535, 65535, 3);
    step();
    chk("wide_dist", 128'(nb_dist[32:0]), 128'(64'd8589672450));
    run_classify("wide", 3, 1);

    // asynchronous reset mid-vote
    classify = 1'b1;
    step();
    classify = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_count", 128'(nb_count), 128'(0));
    chk("arst_dist", 128'(nb_dist), 128'(0));
    chk("arst_result", 128'({result_label, result_votes}), 128'(0));
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    chk("arst_no_done", 128'(saw_done), 128'(0));

    // load + classify + beat in one cycle: load wins, nothing else happens
    load(0, 0);
    train(1, 1, 1);
    step();
    test_load = 1'b1; classify = 1'b1; train_valid = 1'b1;
    test_point = pt(5, 5); train_point = pt(5, 5); train_label = 2'd2;
    #1;
    chk("prio_ready", 128'(train_ready), 128'(0));
    step();
    test_load = 1'b0; classify = 1'b0; train_valid = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    chk("prio_no_cls", 128'(saw_done), 128'(0));
    chk("prio_empty", 128'(nb_count), 128'(0));
    train(5, 5, 1);
    step();
    chk("prio_count", 128'(nb_count), 128'(1));
    chk("prio_query", 128'(nb_dist[32:0]), 128'(0));
    chk("prio_label", 128'(nb_label[1:0]), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
